// File: rtl/seven_seg_pkg.sv
// Shared types for the seven-segment display path: scan FSM states and
// the decoder nibble width.
package seven_seg_pkg;
  localparam int HEX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;
endpackage

// File: rtl/seven_seg_slot_timer.sv
// Per-slot cycle counter for the scan controller. Flags the last blanking
// cycle and the last cycle of the slot; wraps to zero after the slot.
module seven_seg_slot_timer #(
  parameter int SLOT_CYCLES  = 6750,
  parameter int BLANK_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic blank_done,
  output logic slot_end
);
  localparam int CNT_W = $clog2(SLOT_CYCLES);

  logic [CNT_W-1:0] cnt_r;

  assign blank_done = (cnt_r == CNT_W'(BLANK_CYCLES - 1));
  assign slot_end   = (cnt_r == CNT_W'(SLOT_CYCLES - 1));

  // slot cycle counter, cleared while idle and wrapped at slot end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (run) begin
      cnt_r <= slot_end ? '0 : cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller: one shared hex decoder driven across
// N_DIGITS digits with a dark guard at each slot start and per-frame snapshots.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SLOT_CYCLES  = 6750,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               en_i,
  input  logic [HEX_W*N_DIGITS-1:0]                          value_i,
  input  logic [N_DIGITS-1:0]                                dp_i,
  input  logic [N_DIGITS-1:0]                                blank_i,
  output logic [HEX_W-1:0]                                   hex_o,
  output logic                                               dp_o,
  output logic [N_DIGITS-1:0]                                dig_en_n_o,
  output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] digit_idx_o,
  output logic                                               frame_o
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  scan_state_t                state_r, state_s;
  logic [IDX_W-1:0]           idx_r, idx_s;
  logic                       load_s, frame_s, clr_s, run_s;
  logic                       blank_done_s, slot_end_s;
  logic [HEX_W*N_DIGITS-1:0]  shadow_val_r, shadow_val_s;
  logic [N_DIGITS-1:0]        shadow_dp_r, shadow_dp_s;
  logic [N_DIGITS-1:0]        shadow_blank_r, shadow_blank_s;
  logic [HEX_W-1:0]           sel_hex_s;
  logic                       sel_dp_s, sel_blank_s;
  logic [N_DIGITS-1:0]        dig_en_n_s;

  seven_seg_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr_s),
    .run        (run_s),
    .blank_done (blank_done_s),
    .slot_end   (slot_end_s)
  );

  // next-state, digit index and snapshot/frame control
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    load_s  = 1'b0;
    frame_s = 1'b0;
    clr_s   = 1'b0;
    run_s   = 1'b0;
    if (!en_i) begin
      state_s = IDLE;
      idx_s   = '0;
      clr_s   = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = BLANK;
          idx_s   = '0;
          load_s  = 1'b1;
          clr_s   = 1'b1;
        end
        BLANK: begin
          run_s   = 1'b1;
          state_s = blank_done_s ? SHOW : BLANK;
        end
        SHOW: begin
          run_s = 1'b1;
          if (slot_end_s) begin
            state_s = BLANK;
            if (idx_r == LAST_IDX) begin
              idx_s   = '0;
              load_s  = 1'b1;
              frame_s = 1'b1;
            end else begin
              idx_s = idx_r + IDX_W'(1);
            end
          end else begin
            state_s = SHOW;
          end
        end
        default: begin
          state_s = IDLE;
          idx_s   = '0;
          clr_s   = 1'b1;
        end
      endcase
    end
  end

  // outputs are computed from next-cycle state so they register in step with it
  always_comb begin
    shadow_val_s   = load_s ? value_i : shadow_val_r;
    shadow_dp_s    = load_s ? dp_i    : shadow_dp_r;
    shadow_blank_s = load_s ? blank_i : shadow_blank_r;
    sel_hex_s      = '0;
    sel_dp_s       = 1'b0;
    sel_blank_s    = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      sel_hex_s   = (idx_s == IDX_W'(k)) ? shadow_val_s[k*HEX_W +: HEX_W] : sel_hex_s;
      sel_dp_s    = (idx_s == IDX_W'(k)) ? shadow_dp_s[k]                 : sel_dp_s;
      sel_blank_s = (idx_s == IDX_W'(k)) ? shadow_blank_s[k]              : sel_blank_s;
    end
    for (int k = 0; k < N_DIGITS; k++) begin
      dig_en_n_s[k] = !((state_s == SHOW) && !sel_blank_s && (idx_s == IDX_W'(k)));
    end
  end

  // state, shadow and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      idx_r          <= '0;
      shadow_val_r   <= '0;
      shadow_dp_r    <= '0;
      shadow_blank_r <= '0;
      hex_o          <= '0;
      dp_o           <= 1'b0;
      dig_en_n_o     <= '1;
      digit_idx_o    <= '0;
      frame_o        <= 1'b0;
    end else begin
      state_r        <= state_s;
      idx_r          <= idx_s;
      shadow_val_r   <= shadow_val_s;
      shadow_dp_r    <= shadow_dp_s;
      shadow_blank_r <= shadow_blank_s;
      hex_o          <= (state_s == IDLE) ? hex_o : sel_hex_s;
      dp_o           <= (state_s == IDLE) ? dp_o  : sel_dp_s;
      dig_en_n_o     <= dig_en_n_s;
      digit_idx_o    <= idx_s;
      frame_o        <= frame_s;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized self-checking bench for seven_seg_scan_ctrl against a
// cycle-count based model of the scan timeline (4-digit and 1-digit builds).
module tb_seven_seg_scan_ctrl;
  localparam int N = 4;
  localparam int S = 8;
  localparam int B = 2;

  logic        clk;
  logic        rst_n, en_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i, blank_i;
  logic [3:0]  hex_o;
  logic        dp_o;
  logic [3:0]  dig_en_n_o;
  logic [1:0]  digit_idx_o;
  logic        frame_o;

  logic        rst1_n, en1;
  logic [3:0]  value1;
  logic        dp1, blank1;
  logic [3:0]  hex1;
  logic        dp1_o;
  logic        dig1;
  logic        idx1;
  logic        frame1;

  int n_vec = 0;
  int n_err = 0;

  seven_seg_scan_ctrl #(.N_DIGITS(N), .SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .value_i(value_i), .dp_i(dp_i),
    .blank_i(blank_i), .hex_o(hex_o), .dp_o(dp_o), .dig_en_n_o(dig_en_n_o),
    .digit_idx_o(digit_idx_o), .frame_o(frame_o)
  );

  seven_seg_scan_ctrl #(.N_DIGITS(1), .SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut1 (
    .clk(clk), .rst_n(rst1_n), .en_i(en1), .value_i(value1), .dp_i(dp1),
    .blank_i(blank1), .hex_o(hex1), .dp_o(dp1_o), .dig_en_n_o(dig1),
    .digit_idx_o(idx1), .frame_o(frame1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: cycles elapsed since the scan started, plus frame snapshot
  bit          m_active = 1'b0;
  int          m_c = 0;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_blank;
  logic [3:0]  m_hex;
  logic        m_dpo;

  task automatic snap();
    m_val   = value_i;
    m_dp    = dp_i;
    m_blank = blank_i;
  endtask

  task automatic model_step();
    int slot;
    if (!rst_n) begin
      m_active = 1'b0;
      m_hex    = 4'h0;
      m_dpo    = 1'b0;
    end else if (!en_i) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_c      = 0;
      snap();
    end else begin
      m_c++;
      if (m_c % (S * N) == 0) snap();
    end
    if (m_active) begin
      slot  = (m_c / S) % N;
      m_hex = m_val[slot*4 +: 4];
      m_dpo = m_dp[slot];
    end
  endtask

  // {dig_en_n, hex, dp, frame, idx}
  function automatic logic [11:0] exp_vec();
    logic [3:0] dig;
    logic       fr;
    logic [1:0] ix;
    int         slot, pos;
    dig = 4'b1111;
    fr  = 1'b0;
    ix  = 2'd0;
    if (m_active) begin
      slot = (m_c / S) % N;
      pos  = m_c % S;
      ix   = 2'(slot);
      fr   = (m_c > 0) && (m_c % (S * N) == 0);
      if (pos >= B && !m_blank[slot]) dig[slot] = 1'b0;
    end
    return {dig, m_hex, m_dpo, fr, ix};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // digit selects must never have more than one digit on
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_vec++;
      if ($countones(~dig_en_n_o) > 1) begin
        n_err++;
        $display("FAIL onehot t=%0t dig_en_n_o=%b required at most one low", $time, dig_en_n_o);
      end
    end
  end

  task automatic test_reset();
    rst_n   = 1'b0;
    en_i    = 1'b1;
    value_i = 16'($urandom);
    dp_i    = 4'($urandom);
    blank_i = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o} !== {4'b1111, 4'h0, 1'b0, 1'b0, 2'd0}) begin
        n_err++;
        $display("FAIL reset cyc=%0d got=%h required=%h", i,
                 {dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o}, {4'b1111, 4'h0, 1'b0, 1'b0, 2'd0});
      end
    end
  endtask

  task automatic test_scan();
    rst_n   = 1'b1;
    en_i    = 1'b1;
    value_i = 16'h4321;
    dp_i    = 4'($urandom);
    blank_i = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_vec++;
      if ({dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL scan cyc=%0d got=%h required=%h", i, {dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o}, exp_vec());
      end
      n_vec++;
      if (frame_o !== (i == 32)) begin
        n_err++;
        $display("FAIL scan_frame cyc=%0d got=%b required=%b", i, frame_o, (i == 32));
      end
      value_i = 16'($urandom);
    end
  endtask

  task automatic test_snapshot();
    en_i = 1'b0;
    tick();
    en_i    = 1'b1;
    value_i = 16'h4321;
    for (int i = 0; i < 64; i++) begin
      tick();
      n_vec++;
      if ({dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL snapshot cyc=%0d got=%h required=%h", i, {dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o}, exp_vec());
      end
      if (i == 27 || i == 32) begin
        n_vec++;
        if (hex_o !== ((i == 27) ? 4'h4 : 4'hD)) begin
          n_err++;
          $display("FAIL snapshot_hex cyc=%0d got=%h required=%h", i, hex_o, (i == 27) ? 4'h4 : 4'hD);
        end
      end
      if (i == 10) value_i = 16'hABCD;
    end
  endtask

  task automatic test_blank();
    en_i = 1'b0;
    tick();
    en_i    = 1'b1;
    value_i = 16'h4321;
    blank_i = 4'b0100;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_vec++;
      if ({dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL blank cyc=%0d got=%h required=%h", i, {dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o}, exp_vec());
      end
      if (i >= 16 && i < 24) begin
        n_vec++;
        if (dig_en_n_o !== 4'b1111 || hex_o !== 4'h3) begin
          n_err++;
          $display("FAIL blank_slot2 cyc=%0d got=%b/%h required=1111/3", i, dig_en_n_o, hex_o);
        end
      end
    end
    blank_i = 4'b0000;
  endtask

  task automatic test_disable();
    en_i = 1'b0;
    tick();
    en_i    = 1'b1;
    value_i = 16'($urandom);
    for (int i = 0; i < 14; i++) begin
      tick();
      n_vec++;
      if ({dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL disable_run cyc=%0d got=%h required=%h", i, {dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o}, exp_vec());
      end
    end
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o} !== exp_vec() || dig_en_n_o !== 4'b1111) begin
        n_err++;
        $display("FAIL disable_idle cyc=%0d got=%h required=%h", i, {dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o}, exp_vec());
      end
    end
    en_i    = 1'b1;
    value_i = 16'($urandom);
    for (int i = 0; i < 12; i++) begin
      tick();
      n_vec++;
      if ({dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL disable_restart cyc=%0d got=%h required=%h", i, {dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o}, exp_vec());
      end
      if (i == 0) begin
        n_vec++;
        if (dig_en_n_o !== 4'b1111 || digit_idx_o !== 2'd0 || hex_o !== m_val[3:0]) begin
          n_err++;
          $display("FAIL restart_slot0 got=%b/%0d/%h required=1111/0/%h", dig_en_n_o, digit_idx_o, hex_o, m_val[3:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      value_i = 16'($urandom);
      dp_i    = 4'($urandom);
      blank_i = 4'($urandom);
      en_i    = ($urandom_range(0, 99) < 97);
      rst_n   = ($urandom_range(0, 299) != 0);
      tick();
      n_vec++;
      if ({dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%h required=%h", i, {dig_en_n_o, hex_o, dp_o, frame_o, digit_idx_o}, exp_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int         c;
    logic [3:0] v_pre, sv;
    logic       d_pre, sd;
    rst1_n = 1'b0;
    en1    = 1'b1;
    tick();
    rst1_n = 1'b1;
    c      = -1;
    sv     = 4'h0;
    sd     = 1'b0;
    for (int i = 0; i < 50; i++) begin
      v_pre = value1;
      d_pre = dp1;
      tick();
      c++;
      if (c % S == 0) begin
        sv = v_pre;
        sd = d_pre;
      end
      n_vec++;
      if ({dig1, hex1, dp1_o, frame1, idx1} !== {!(c % S >= B), sv, sd, (c > 0 && c % S == 0), 1'b0}) begin
        n_err++;
        $display("FAIL single cyc=%0d got=%b required=%b", c, {dig1, hex1, dp1_o, frame1, idx1},
                 {!(c % S >= B), sv, sd, (c > 0 && c % S == 0), 1'b0});
      end
      value1 = 4'($urandom);
      dp1    = 1'($urandom);
    end
  endtask

  initial begin
    rst1_n  = 1'b0;
    en1     = 1'b0;
    value1  = 4'($urandom);
    dp1     = 1'b0;
    blank1  = 1'b0;
    rst_n   = 1'b0;
    en_i    = 1'b0;
    value_i = 16'h0;
    dp_i    = 4'h0;
    blank_i = 4'h0;
    #2;
    test_reset();
    test_scan();
    test_snapshot();
    test_blank();
    test_disable();
    test_random();
    test_single();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
